// File: rtl/ps2_keycode_display.sv
// ps2_keycode_display: PS/2 set-2 scancode tracker feeding a shifting seven-segment digit register
// Ports:
//   clk, reset (async, active-high)
//   scancode_data/scancode_valid : received byte and its one-cycle strobe
//   clear_display                : synchronous clear of digits, count, last symbol and key state
//   display_flat                 : NUM_DIGITS glyphs, digit k at [7k+6:7k], digit 0 newest
//   last_symbol                  : last accepted symbol, 36 = none
//   symbol_valid                 : one-cycle pulse per accepted symbol
//   key_held                     : a recognised key is currently pressed
//   digit_count                  : non-blank digits, 0..NUM_DIGITS
module ps2_keycode_display #(
  parameter int NUM_DIGITS     = 6,
  parameter int ACTIVE_LOW_SEG = 1,
  parameter int REPEAT_FILTER  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              scancode_data,
  input  logic                    scancode_valid,
  input  logic                    clear_display,
  output logic [7*NUM_DIGITS-1:0] display_flat,
  output logic [5:0]              last_symbol,
  output logic                    symbol_valid,
  output logic                    key_held,
  output logic [3:0]              digit_count
);
  localparam int DW = 7*NUM_DIGITS;
  localparam logic [3:0] ND = 4'(NUM_DIGITS);
  localparam logic [6:0] BLANK = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;
  localparam logic [7:0] CODES [36] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [6:0] GLYPH [36] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h08, 7'h00, 7'h46, 7'h40, 7'h06, 7'h0E, 7'h02, 7'h09, 7'h79, 7'h71,
    7'h09, 7'h47, 7'h40, 7'h2B, 7'h40, 7'h0C, 7'h40, 7'h08, 7'h12, 7'h07,
    7'h41, 7'h41, 7'h40, 7'h40, 7'h19, 7'h24};

  typedef enum logic [1:0] {IDLE, BREAK, EXT, EXT_BREAK} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   disp_q, disp_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [5:0]      last_q, last_d;
  logic            sv_q, sv_d;
  logic            held_q, held_d;
  logic [7:0]      code_q, code_d;
  logic [5:0]      sym;
  logic [6:0]      gl;
  logic            repeat_hit;

  always_comb begin
    sym = 6'd36;
    gl = 7'h7F;
    for (int i = 0; i < 36; i++)
      if (scancode_data == CODES[i]) begin
        sym = 6'(i);
        gl = GLYPH[i];
      end
    repeat_hit = (REPEAT_FILTER != 0) && held_q && (scancode_data == code_q);
    state_d = state_q;
    disp_d = disp_q;
    cnt_d = cnt_q;
    last_d = last_q;
    sv_d = 1'b0;
    held_d = held_q;
    code_d = code_q;
    if (clear_display) begin
      state_d = IDLE;
      disp_d = {NUM_DIGITS{BLANK}};
      cnt_d = 4'd0;
      last_d = 6'd36;
      held_d = 1'b0;
    end else if (scancode_valid) begin
      case (state_q)
        IDLE:
          if (scancode_data == 8'hF0) state_d = BREAK;
          else if (scancode_data == 8'hE0) state_d = EXT;
          else if (scancode_data == 8'h66) begin
            disp_d = DW'({BLANK, disp_q} >> 7);
            cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
          end else if (sym != 6'd36 && !repeat_hit) begin
            disp_d = DW'({disp_q, (ACTIVE_LOW_SEG != 0) ? gl : ~gl});
            cnt_d = (cnt_q == ND) ? cnt_q : cnt_q + 4'd1;
            last_d = sym;
            sv_d = 1'b1;
            held_d = 1'b1;
            code_d = scancode_data;
          end
        BREAK: begin
          state_d = IDLE;
          held_d = (scancode_data == code_q) ? 1'b0 : held_q;
        end
        EXT: state_d = (scancode_data == 8'hF0) ? EXT_BREAK : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      disp_q <= {NUM_DIGITS{BLANK}};
      cnt_q <= 4'd0;
      last_q <= 6'd36;
      sv_q <= 1'b0;
      held_q <= 1'b0;
      code_q <= 8'h00;
    end else begin
      state_q <= state_d;
      disp_q <= disp_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      sv_q <= sv_d;
      held_q <= held_d;
      code_q <= code_d;
    end

  assign display_flat = disp_q;
  assign last_symbol = last_q;
  assign symbol_valid = sv_q;
  assign key_held = held_q;
  assign digit_count = cnt_q;
endmodule

// File: tb/tb_ps2_keycode_display.sv
// tb_ps2_keycode_display: directed and randomized check of ps2_keycode_display against a symbol-queue model
module tb_ps2_keycode_display;
  localparam int N = 6;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] data = 8'h00;
  logic valid = 1'b0;
  logic clr = 1'b0;
  logic [7*N-1:0] display_flat;
  logic [5:0] last_symbol;
  logic symbol_valid;
  logic key_held;
  logic [3:0] digit_count;

  always #5 clk = ~clk;

  ps2_keycode_display #(.NUM_DIGITS(N), .ACTIVE_LOW_SEG(1), .REPEAT_FILTER(1)) dut (
    .clk(clk), .reset(reset), .scancode_data(data), .scancode_valid(valid),
    .clear_display(clr), .display_flat(display_flat), .last_symbol(last_symbol),
    .symbol_valid(symbol_valid), .key_held(key_held), .digit_count(digit_count));

  byte unsigned codes [36] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
    8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C,
    8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [6:0] glyph [36] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10,
    7'h08, 7'h00, 7'h46, 7'h40, 7'h06, 7'h0E, 7'h02, 7'h09, 7'h79, 7'h71,
    7'h09, 7'h47, 7'h40, 7'h2B, 7'h40, 7'h0C, 7'h40, 7'h08, 7'h12, 7'h07,
    7'h41, 7'h41, 7'h40, 7'h40, 7'h19, 7'h24};

  int q[$];
  int m_cnt, m_last, pulses, vectors, errs;
  bit m_sv, m_held, got_f0, got_e0;
  byte unsigned m_code, last_byte;

  function automatic int sym_of(byte unsigned c);
    foreach (codes[i]) if (codes[i] == c) return i;
    return -1;
  endfunction

  function automatic logic [7*N-1:0] exp_disp();
    logic [7*N-1:0] r;
    for (int k = 0; k < N; k++) r[7*k+:7] = (q[k] < 0) ? 7'h7F : glyph[q[k]];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_blank();
    q.delete();
    repeat (N) q.push_back(-1);
    m_cnt = 0;
    m_last = 36;
    m_held = 0;
    got_f0 = 0;
    got_e0 = 0;
  endtask

  task automatic model_step(input byte unsigned d, input bit v, input bit c);
    int s;
    m_sv = 0;
    if (c) model_blank();
    else if (v) begin
      if (got_f0) begin
        if (!got_e0 && d == m_code) m_held = 0;
        got_f0 = 0;
        got_e0 = 0;
      end else if (got_e0) begin
        if (d == 8'hF0) got_f0 = 1;
        else got_e0 = 0;
      end else if (d == 8'hF0) got_f0 = 1;
      else if (d == 8'hE0) got_e0 = 1;
      else if (d == 8'h66) begin
        void'(q.pop_front());
        q.push_back(-1);
        if (m_cnt > 0) m_cnt--;
      end else begin
        s = sym_of(d);
        if (s >= 0 && !(m_held && d == m_code)) begin
          q.push_front(s);
          void'(q.pop_back());
          if (m_cnt < N) m_cnt++;
          m_last = s;
          m_sv = 1;
          m_held = 1;
          m_code = d;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".display"}, 64'(display_flat), 64'(exp_disp()));
    chk({tag, ".count"}, 64'(digit_count), 64'(m_cnt));
    chk({tag, ".last"}, 64'(last_symbol), 64'(m_last));
    chk({tag, ".pulse"}, 64'(symbol_valid), 64'(m_sv));
    chk({tag, ".held"}, 64'(key_held), 64'(m_held));
  endtask

  task automatic step(input byte unsigned d, input bit v = 1, input bit c = 0);
    @(negedge clk);
    data = d;
    valid = v;
    clr = c;
    model_step(d, v, c);
    @(posedge clk);
    #1;
    valid = 0;
    clr = 0;
    check_all("step");
    if (symbol_valid) pulses++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    valid = 0;
    clr = 0;
    reset = 1;
    model_blank();
    m_sv = 0;
    m_code = 0;
    #2;
    check_all("reset");
    @(negedge clk);
    reset = 0;
    pulses = 0;
  endtask

  initial begin
    vectors = 0;
    errs = 0;
    do_reset();
    chk("reset_blank", 64'(display_flat), 64'({N{7'h7F}}));
    chk("reset_last", 64'(last_symbol), 64'd36);

    step(8'h16); step(8'hF0); step(8'h16);
    chk("p1_d0", 64'(display_flat[6:0]), 64'h79);
    chk("p1_cnt", 64'(digit_count), 64'd1);
    chk("p1_last", 64'(last_symbol), 64'd1);
    chk("p1_held", 64'(key_held), 64'd0);
    chk("p1_pulses", 64'(pulses), 64'd1);

    do_reset();
    step(8'h1C); step(8'h1C); step(8'h1C); step(8'hF0); step(8'h1C); step(8'h1C);
    chk("p2_pulses", 64'(pulses), 64'd2);
    chk("p2_d10", 64'(display_flat[13:0]), 64'({7'h08, 7'h08}));
    chk("p2_cnt", 64'(digit_count), 64'd2);

    do_reset();
    foreach (codes[i]) if (i >= 1 && i <= 7) step(codes[i]);
    chk("p3_disp", 64'(display_flat), 64'({7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78}));
    chk("p3_cnt", 64'(digit_count), 64'd6);
    step(8'h66);
    chk("p3_bs_disp", 64'(display_flat), 64'({7'h7F, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}));
    chk("p3_bs_cnt", 64'(digit_count), 64'd5);

    do_reset();
    step(8'hE0); step(8'h75); step(8'hE0); step(8'hF0); step(8'h75); step(8'h45);
    chk("p4_pulses", 64'(pulses), 64'd1);
    chk("p4_d0", 64'(display_flat[6:0]), 64'h40);
    chk("p4_cnt", 64'(digit_count), 64'd1);

    do_reset();
    step(8'hF0);
    do_reset();
    step(8'h2E);
    chk("p5_d0", 64'(display_flat[6:0]), 64'h12);
    chk("p5_cnt", 64'(digit_count), 64'd1);

    do_reset();
    step(8'h16);
    step(8'h45, 1, 1);
    chk("p6_disp", 64'(display_flat), 64'({N{7'h7F}}));
    chk("p6_cnt", 64'(digit_count), 64'd0);
    chk("p6_pulse", 64'(symbol_valid), 64'd0);
    step(8'h45);
    chk("p6_d0", 64'(display_flat[6:0]), 64'h40);

    last_byte = 8'h45;
    for (int n = 0; n < 800; n++) begin
      byte unsigned d;
      int pick;
      pick = $urandom_range(0, 9);
      d = (pick <= 4) ? codes[$urandom_range(0, 35)] :
          (pick == 5) ? 8'hF0 : (pick == 6) ? 8'hE0 : (pick == 7) ? 8'h66 :
          (pick == 8) ? 8'($urandom) : last_byte;
      last_byte = d;
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(d, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
